// File: rtl/tv_stimulus_checker.sv
// rtl/tv_stimulus_checker.sv - on-chip test-vector engine for a small combinational block
module tv_stimulus_checker #(
  parameter int IN_W  = 3,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [IN_W:0]   load_data,
  input  logic [AW:0]     num_vec,
  input  logic            start,
  output logic [IN_W-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            err_pulse,
  output logic [IN_W-1:0] err_vec,
  output logic [AW:0]     err_count,
  output logic [AW:0]     vec_count
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [IN_W:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     nvec_q, nvec_d;
  logic            exp_q, exp_d;
  logic [IN_W-1:0] dut_in_q, dut_in_d;
  logic [IN_W-1:0] err_vec_q, err_vec_d;
  logic [AW:0]     err_count_q, err_count_d;
  logic [AW:0]     vec_count_q, vec_count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_pulse_q, err_pulse_d;
  logic            load_vec;
  logic [AW:0]     nv_clamped;
  logic            idle_like;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

  // Vector memory: writable only while no run is in progress; contents survive reset
  always_ff @(posedge clk) begin
    if (load_en && idle_like) begin
      mem[load_addr] <= load_data;
    end
  end

  // Next-state and registered-output computation for the run sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nvec_d      = nvec_q;
    exp_d       = exp_q;
    dut_in_d    = dut_in_q;
    err_vec_d   = err_vec_q;
    err_count_d = err_count_q;
    vec_count_d = vec_count_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_pulse_d = 1'b0;
    load_vec    = 1'b0;
    nv_clamped  = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          nvec_d      = nv_clamped;
          err_count_d = '0;
          vec_count_d = '0;
          idx_d       = '0;
          if (nv_clamped == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = S_APPLY;
            done_d   = 1'b0;
            busy_d   = 1'b1;
            load_vec = 1'b1;
          end
        end
      end
      S_APPLY: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        vec_count_d = vec_count_q + ONE_C;
        if (dut_y != exp_q) begin
          err_pulse_d = 1'b1;
          err_vec_d   = dut_in_q;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ONE_C;
          end
        end
        if ((vec_count_q + ONE_C) == nvec_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d    = idx_q + 1'b1;
          state_d  = S_APPLY;
          load_vec = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    // Stimulus and its expected bit are captured on the edge that enters APPLY
    if (load_vec) begin
      dut_in_d = mem[idx_d][IN_W:1];
      exp_d    = mem[idx_d][0];
    end
  end

  // State register; reset aborts any run and returns to IDLE without done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      nvec_q      <= '0;
      exp_q       <= 1'b0;
      dut_in_q    <= '0;
      err_vec_q   <= '0;
      err_count_q <= '0;
      vec_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nvec_q      <= nvec_d;
      exp_q       <= exp_d;
      dut_in_q    <= dut_in_d;
      err_vec_q   <= err_vec_d;
      err_count_q <= err_count_d;
      vec_count_q <= vec_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_pulse = err_pulse_q;
  assign err_vec   = err_vec_q;
  assign err_count = err_count_q;
  assign vec_count = vec_count_q;

endmodule

// File: doc/tv_stimulus_checker.md
Name: tv_stimulus_checker

Overview:
- Synthesizable test-vector engine that sits directly upstream of a 3-input, 1-output combinational logic block.
- Holds a small vector memory. Each entry packs {a, b, c, yexpected}.
- On start, drives each vector's inputs to the block, samples its output, and compares it with the expected bit.
- Reports error count, failing-vector inputs and completion, replacing the simulation-only $readmemb flow on-chip.

Parameters:
- IN_W, 3, number of stimulus inputs driven to the logic block; memory word width is IN_W+1.
- DEPTH, 16, number of vector memory entries.
- AW, 4, memory address width; DEPTH must equal 2**AW.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_en  input  1  write strobe for vector memory.
- load_addr  input  AW  write address.
- load_data  input  IN_W+1  vector word {inputs[IN_W-1:0], expected}; the expected bit is the LSB.
- num_vec  input  AW+1  number of vectors to run (0..DEPTH); sampled at start.
- start  input  1  single-cycle request to begin a run.
- dut_in  output  IN_W  registered stimulus {a,b,c} to the logic block.
- dut_y  input  1  logic block output.
- busy  output  1  high from start acceptance until done.
- done  output  1  run complete; held until next accepted start or reset.
- err_pulse  output  1  one-cycle pulse on each mismatch.
- err_vec  output  IN_W  inputs of the most recent failing vector.
- err_count  output  AW+1  mismatches in current run, saturating at all-ones.
- vec_count  output  AW+1  vectors checked in current run.

Behaviour:
- Reset (reset=0, async): state=IDLE; dut_in, err_vec, err_count and vec_count are 0; busy, done and err_pulse are 0. Memory contents are not reset.
- Reset mid-run aborts immediately. On release, the engine is in IDLE with no done.
- FSM states:
  - IDLE: start=1 latches num_vec, clears err_count and vec_count, clears done, and sets idx=0. Next state is APPLY, or DONE if num_vec=0.
  - DONE: behaves like IDLE for start handling, so a run can be restarted from DONE.
  - APPLY: dut_in is registered from mem[idx] inputs on entry, and the expected bit is latched. Next state is always CHECK.
  - CHECK: dut_in is held. At the ending edge, dut_y is compared with the latched expected bit and vec_count increments. On mismatch, err_pulse=1 for the following cycle, err_vec=dut_in, and err_count increments unless it is saturated. If vec_count+1 == latched num_vec, next state is DONE; otherwise idx increments and next state is APPLY.
  - DONE: done=1, busy=0; dut_in holds the last vector.
- Throughput: 2 cycles per vector. done rises 2N edges after the edge that sampled start; for N=0, 1 edge.
- busy=1 in APPLY and CHECK only.
- start while busy is ignored. num_vec > DEPTH is clamped to DEPTH.
- Memory write: load_en=1 writes mem[load_addr] at the edge, only in IDLE or DONE. Writes while busy are dropped.
- Settling: dut_y is sampled a full cycle after dut_in changes, so the combinational path must settle in one period.
- dut_y X/Z handling is out of scope; the bench drives known values.

Test Plan:
- Known-good table: load 8 vectors abc=000..111 with expected y = ~b&~c | a&~b = 1,0,0,0,1,1,0,0; num_vec=8; start -> done after 16 edges, vec_count=8, err_count=0, no err_pulse, dut_in walks 000..111.
- Injected faults: flip expected on vectors 3 (abc=011) and 6 (abc=110) -> err_count=2, err_pulse exactly twice, final err_vec=110, done after 16 edges.
- num_vec=0 with start -> done=1 one edge later, busy never high, err_count=0, vec_count=0.
- Reset low at vector 4 CHECK, then released -> all outputs 0, state IDLE. A fresh start runs the full 8 vectors cleanly.
- start and load_en pulsed while busy -> run unaffected, memory unchanged (rerun gives identical results). Restart from DONE clears err_count and reruns.
- Saturation: DEPTH=16, all 16 expected bits inverted, AW=4 -> err_count=16 (fits in AW+1). With a bench-forced count preload, saturates at 31 and does not wrap.
